id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 XLEN, 32, datapath width; all data/pc/imm ports are XLEN bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  decode presents an instruction.
REQ-005 in_ready  output  1  stage can accept this cycle.
REQ-006 in_pc, in_imm  input  XLEN  instruction PC, decoded immediate.
REQ-007 in_rs1_addr, in_rs2_addr, in_rd_addr  input  5  source/destination register indices.
REQ-008 in_rs1_data, in_rs2_data  input  XLEN  register-file read data.
REQ-009 in_alu_op  input  4  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 15 PASS.
REQ-010 in_a_sel, in_b_sel, in_reg_write  input  1  a: 0=rs1/1=pc; b: 0=rs2/1=imm; writes rd.
REQ-011 flush  input  1  kill held and incoming instruction.
REQ-012 mem_reg_write, mem_rd_addr[4:0], mem_result[XLEN]  input  MEM-stage forwarding source.
REQ-013 wb_reg_write, wb_rd_addr[4:0], wb_result[XLEN]  input  WB-stage forwarding source.
REQ-014 out_valid  output  1  ALU operands valid; out_ready input 1 downstream accepts.
REQ-015 alu_op[4], alu_a[XLEN], alu_b[XLEN]  output  drive the execute ALU directly.
REQ-016 out_pc[XLEN], out_rd_addr[5], out_reg_write[1], out_rs2_fwd[XLEN]  output  carried fields; rs2 value for stores.

Function
REQ-017 Stage SHALL be one register slot; in_ready = !out_valid || out_ready (combinational, no flush dependency).
REQ-018 Capture SHALL occur when in_valid && in_ready && !flush; out_valid=1 next cycle; latency exactly 1 cycle.
REQ-019 When out_valid && out_ready and no new capture, out_valid SHALL clear next cycle.
REQ-020 While out_valid && !out_ready, all held fields SHALL remain stable except REQ-023 rs-data refresh.
REQ-021 flush SHALL clear out_valid next cycle and discard any same-cycle incoming beat (beat counts as consumed if in_ready=1); flush beats capture.
REQ-022 Forwarding (combinational on outputs) for each of rs1/rs2: if mem_reg_write && mem_rd_addr==rsN && rsN!=0 use mem_result; else if wb_reg_write && wb_rd_addr==rsN && rsN!=0 use wb_result; else held rsN data. MEM SHALL have priority over WB.
REQ-023 While holding a valid instruction, if wb_reg_write && wb_rd_addr==held rsN && rsN!=0, held rsN data SHALL be overwritten with wb_result at that edge (stall-safe refresh).
REQ-024 On capture, rsN data SHALL be the forwarded value of in_rsN_data using the same WB rule (covers same-cycle register-file write-through).
REQ-025 alu_a = a_sel ? held pc : fwd rs1; alu_b = b_sel ? held imm : fwd rs2; out_rs2_fwd = fwd rs2 regardless of b_sel.
REQ-026 alu_op SHALL be held op when out_valid, else 15 (PASS); op codes 8-14 SHALL pass through unchanged.
REQ-027 out_reg_write SHALL equal held reg_write && out_valid; rd_addr 0 SHALL force out_reg_write=0.

Reset
REQ-028 On rst at an edge: out_valid=0, held op=15, all held data/pc/imm/addr/flags=0; rst SHALL override flush and capture.
REQ-029 Reset mid-stall SHALL drop the held instruction; in_ready=1 in the first cycle after reset.

Verification
REQ-030 ADD x3,x1,x2 with rs1=5, rs2=7, no hazards -> next cycle out_valid=1, alu_op=0, alu_a=5, alu_b=7, out_rd_addr=3.
REQ-031 rs1=x4 held 1, mem writes x4=0x10 and wb writes x4=0x20 same cycle -> alu_a=0x10; with mem_rd_addr=0 and rs1=x0 -> alu_a=held value (0).
REQ-032 out_ready=0 for 3 cycles, wb writes rs2 x6=0xAB in cycle 2 -> after wb deasserts alu_b stays 0xAB; in_ready=0 throughout stall.
REQ-033 flush with in_valid=1 while holding valid -> next cycle out_valid=0, alu_op=15, out_reg_write=0.
REQ-034 Back-to-back in_valid with out_ready=1 for 4 instrs -> 4 consecutive out_valid cycles, in_ready=1 always, order preserved.
REQ-035 rst asserted during stall with out_valid=1 -> next cycle out_valid=0, alu_op=15, in_ready=1.

Source files
------------

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage_if
//  Description : Decode-to-execute bus. It carries the decode handshake, the
//                MEM/WB forwarding sources, the ALU operand outputs and the
//                downstream handshake.
//  Revision    : 1.0  initial release
// ============================================================================
interface id_ex_stage_if #(
    parameter int XLEN = 32
);
    // decode side
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_imm;
    logic [4:0]      in_rs1_addr;
    logic [4:0]      in_rs2_addr;
    logic [4:0]      in_rd_addr;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic [3:0]      in_alu_op;
    logic            in_a_sel;
    logic            in_b_sel;
    logic            in_reg_write;
    logic            flush;
    // forwarding sources
    logic            mem_reg_write;
    logic [4:0]      mem_rd_addr;
    logic [XLEN-1:0] mem_result;
    logic            wb_reg_write;
    logic [4:0]      wb_rd_addr;
    logic [XLEN-1:0] wb_result;
    // execute side
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_rd_addr;
    logic            out_reg_write;
    logic [XLEN-1:0] out_rs2_fwd;

    // The stage itself
    modport slave (
        input  in_valid, in_pc, in_imm, in_rs1_addr, in_rs2_addr, in_rd_addr,
               in_rs1_data, in_rs2_data, in_alu_op, in_a_sel, in_b_sel,
               in_reg_write, flush, mem_reg_write, mem_rd_addr, mem_result,
               wb_reg_write, wb_rd_addr, wb_result, out_ready,
        output in_ready, out_valid, alu_op, alu_a, alu_b, out_pc, out_rd_addr,
               out_reg_write, out_rs2_fwd
    );

    // The surrounding pipeline driving the stage
    modport master (
        output in_valid, in_pc, in_imm, in_rs1_addr, in_rs2_addr, in_rd_addr,
               in_rs1_data, in_rs2_data, in_alu_op, in_a_sel, in_b_sel,
               in_reg_write, flush, mem_reg_write, mem_rd_addr, mem_result,
               wb_reg_write, wb_rd_addr, wb_result, out_ready,
        input  in_ready, out_valid, alu_op, alu_a, alu_b, out_pc, out_rd_addr,
               out_reg_write, out_rs2_fwd
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : Single-slot ID/EX pipeline register with MEM/WB operand
//                forwarding and stall-safe refresh of held register data.
//  Revision    : 1.0  initial release
// ============================================================================
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    id_ex_stage_if.slave  bus
);
    localparam logic [3:0] C_OP_PASS = 4'hF;

    logic            r_valid;
    logic [3:0]      r_op;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_imm;
    logic [4:0]      r_rd;
    logic            r_a_sel;
    logic            r_b_sel;
    logic            r_reg_write;

    logic            w_in_ready;
    logic            w_capture;
    logic [4:0]      w_in_addr [2];
    logic [XLEN-1:0] w_in_data [2];
    logic [XLEN-1:0] w_fwd     [2];

    // Ready depends only on slot occupancy and downstream, never on flush
    assign w_in_ready = !r_valid || bus.out_ready;
    assign w_capture  = bus.in_valid && w_in_ready && !bus.flush;

    assign w_in_addr[0] = bus.in_rs1_addr;
    assign w_in_addr[1] = bus.in_rs2_addr;
    assign w_in_data[0] = bus.in_rs1_data;
    assign w_in_data[1] = bus.in_rs2_data;

    // Control slot: valid flag plus carried fields
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid     <= 1'b0;
            r_op        <= C_OP_PASS;
            r_pc        <= '0;
            r_imm       <= '0;
            r_rd        <= '0;
            r_a_sel     <= 1'b0;
            r_b_sel     <= 1'b0;
            r_reg_write <= 1'b0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid     <= 1'b1;
            r_op        <= bus.in_alu_op;
            r_pc        <= bus.in_pc;
            r_imm       <= bus.in_imm;
            r_rd        <= bus.in_rd_addr;
            r_a_sel     <= bus.in_a_sel;
            r_b_sel     <= bus.in_b_sel;
            r_reg_write <= bus.in_reg_write;
        end else if (r_valid && bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // One forwarding/refresh unit per source operand (0 = rs1, 1 = rs2)
    for (genvar gi = 0; gi < 2; gi++) begin : g_rs
        logic [4:0]      r_addr;
        logic [XLEN-1:0] r_data;
        logic            w_wb_in_hit;
        logic            w_wb_held_hit;
        logic            w_mem_held_hit;

        assign w_wb_in_hit    = bus.wb_reg_write && (bus.wb_rd_addr == w_in_addr[gi])
                                && (w_in_addr[gi] != 5'd0);
        assign w_wb_held_hit  = bus.wb_reg_write && (bus.wb_rd_addr == r_addr)
                                && (r_addr != 5'd0);
        assign w_mem_held_hit = bus.mem_reg_write && (bus.mem_rd_addr == r_addr)
                                && (r_addr != 5'd0);

        // Capture with WB write-through, else refresh a stalled operand from WB
        always_ff @(posedge clk) begin
            if (rst) begin
                r_addr <= '0;
                r_data <= '0;
            end else if (w_capture) begin
                r_addr <= w_in_addr[gi];
                r_data <= w_wb_in_hit ? bus.wb_result : w_in_data[gi];
            end else if (r_valid && w_wb_held_hit) begin
                r_data <= bus.wb_result;
            end
        end

        // MEM is younger than WB, so it wins
        assign w_fwd[gi] = w_mem_held_hit ? bus.mem_result :
                           w_wb_held_hit  ? bus.wb_result  : r_data;
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = r_valid;
    assign bus.alu_op        = r_valid ? r_op : C_OP_PASS;
    assign bus.alu_a         = r_a_sel ? r_pc  : w_fwd[0];
    assign bus.alu_b         = r_b_sel ? r_imm : w_fwd[1];
    assign bus.out_rs2_fwd   = w_fwd[1];
    assign bus.out_pc        = r_pc;
    assign bus.out_rd_addr   = r_rd;
    assign bus.out_reg_write = r_reg_write && r_valid && (r_rd != 5'd0);
endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Directed vector bench for id_ex_stage: one table row per
//                cycle, plus reset-during-stall and back-to-back sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_id_ex_stage;
    localparam int XLEN = 32;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    id_ex_stage_if #(.XLEN(XLEN)) bus ();

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv, ordy, fl;
        logic [31:0] pc, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2;
        logic [3:0]  op;
        logic        asel, bsel, rw;
        logic        mw;
        logic [4:0]  mrd;
        logic [31:0] mres;
        logic        ww;
        logic [4:0]  wrd;
        logic [31:0] wres;
        logic        e_ir, e_ov;
        logic [3:0]  e_op;
        logic [31:0] e_a, e_b, e_pc;
        logic [4:0]  e_rd;
        logic        e_rw;
        logic [31:0] e_r2;
    } vec_t;

    vec_t vt [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus.in_valid = 0; bus.out_ready = 1; bus.flush = 0;
        bus.in_pc = 0; bus.in_imm = 0; bus.in_rs1_addr = 0; bus.in_rs2_addr = 0;
        bus.in_rd_addr = 0; bus.in_rs1_data = 0; bus.in_rs2_data = 0;
        bus.in_alu_op = 0; bus.in_a_sel = 0; bus.in_b_sel = 0; bus.in_reg_write = 0;
        bus.mem_reg_write = 0; bus.mem_rd_addr = 0; bus.mem_result = 0;
        bus.wb_reg_write = 0; bus.wb_rd_addr = 0; bus.wb_result = 0;
    endtask

    task automatic apply(input vec_t v);
        bus.in_valid = v.iv; bus.out_ready = v.ordy; bus.flush = v.fl;
        bus.in_pc = v.pc; bus.in_imm = v.imm; bus.in_rs1_addr = v.rs1;
        bus.in_rs2_addr = v.rs2; bus.in_rd_addr = v.rd; bus.in_rs1_data = v.d1;
        bus.in_rs2_data = v.d2; bus.in_alu_op = v.op; bus.in_a_sel = v.asel;
        bus.in_b_sel = v.bsel; bus.in_reg_write = v.rw;
        bus.mem_reg_write = v.mw; bus.mem_rd_addr = v.mrd; bus.mem_result = v.mres;
        bus.wb_reg_write = v.ww; bus.wb_rd_addr = v.wrd; bus.wb_result = v.wres;
    endtask

    task automatic check_vec(input int i, input vec_t v);
        chk($sformatf("v%0d in_ready", i),      {31'd0, bus.in_ready},      {31'd0, v.e_ir});
        chk($sformatf("v%0d out_valid", i),     {31'd0, bus.out_valid},     {31'd0, v.e_ov});
        chk($sformatf("v%0d alu_op", i),        {28'd0, bus.alu_op},        {28'd0, v.e_op});
        chk($sformatf("v%0d alu_a", i),         bus.alu_a,                  v.e_a);
        chk($sformatf("v%0d alu_b", i),         bus.alu_b,                  v.e_b);
        chk($sformatf("v%0d out_pc", i),        bus.out_pc,                 v.e_pc);
        chk($sformatf("v%0d out_rd_addr", i),   {27'd0, bus.out_rd_addr},   {27'd0, v.e_rd});
        chk($sformatf("v%0d out_reg_write", i), {31'd0, bus.out_reg_write}, {31'd0, v.e_rw});
        chk($sformatf("v%0d out_rs2_fwd", i),   bus.out_rs2_fwd,            v.e_r2);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // Each row: inputs driven this cycle, outputs expected before the next edge
        // idle after reset
        vt[0]  = '{default:0, ordy:1, e_ir:1, e_op:4'hF};
        // present ADD x3,x1,x2 (5,7)
        vt[1]  = '{default:0, iv:1, ordy:1, pc:32'h100, rs1:1, rs2:2, rd:3, d1:5, d2:7, op:0, rw:1,
                   e_ir:1, e_op:4'hF};
        // ADD visible one cycle later
        vt[2]  = '{default:0, ordy:1, e_ir:1, e_ov:1, e_op:0, e_a:5, e_b:7, e_pc:32'h100, e_rd:3,
                   e_rw:1, e_r2:7};
        // present AND x5,x4,imm with held x4 = 1
        vt[3]  = '{default:0, iv:1, ordy:1, pc:32'h104, imm:32'hFF, rs1:4, rs2:0, rd:5, d1:1, op:2,
                   bsel:1, rw:1, e_ir:1, e_op:4'hF, e_a:5, e_b:7, e_pc:32'h100, e_rd:3, e_r2:7};
        // stall; MEM and WB both write x4: MEM wins
        vt[4]  = '{default:0, ordy:0, mw:1, mrd:4, mres:32'h10, ww:1, wrd:4, wres:32'h20,
                   e_ir:0, e_ov:1, e_op:2, e_a:32'h10, e_b:32'hFF, e_pc:32'h104, e_rd:5, e_rw:1};
        // stall; held x4 was refreshed from WB
        vt[5]  = '{default:0, ordy:0, e_ir:0, e_ov:1, e_op:2, e_a:32'h20, e_b:32'hFF,
                   e_pc:32'h104, e_rd:5, e_rw:1};
        // release
        vt[6]  = '{default:0, ordy:1, e_ir:1, e_ov:1, e_op:2, e_a:32'h20, e_b:32'hFF,
                   e_pc:32'h104, e_rd:5, e_rw:1};
        // present SUB x7,x0,x6
        vt[7]  = '{default:0, iv:1, ordy:1, pc:32'h108, rs1:0, rs2:6, rd:7, d1:0, d2:32'h11, op:1,
                   rw:1, e_ir:1, e_op:4'hF, e_a:32'h20, e_b:32'hFF, e_pc:32'h104, e_rd:5};
        // stall 1; MEM writes x0: no forwarding onto rs1=x0
        vt[8]  = '{default:0, ordy:0, mw:1, mrd:0, mres:32'h99, e_ir:0, e_ov:1, e_op:1, e_a:0,
                   e_b:32'h11, e_pc:32'h108, e_rd:7, e_rw:1, e_r2:32'h11};
        // stall 2; WB writes x6 = 0xAB
        vt[9]  = '{default:0, ordy:0, ww:1, wrd:6, wres:32'hAB, e_ir:0, e_ov:1, e_op:1, e_a:0,
                   e_b:32'hAB, e_pc:32'h108, e_rd:7, e_rw:1, e_r2:32'hAB};
        // stall 3; WB gone, refreshed value stays
        vt[10] = '{default:0, ordy:0, e_ir:0, e_ov:1, e_op:1, e_a:0, e_b:32'hAB,
                   e_pc:32'h108, e_rd:7, e_rw:1, e_r2:32'hAB};
        // release and capture OR x8 (a=pc) in the same cycle
        vt[11] = '{default:0, iv:1, ordy:1, pc:32'h200, rs1:9, rs2:10, rd:8, d1:32'hF0, d2:32'h0F,
                   op:3, asel:1, rw:1, e_ir:1, e_ov:1, e_op:1, e_a:0, e_b:32'hAB,
                   e_pc:32'h108, e_rd:7, e_rw:1, e_r2:32'hAB};
        // capture XOR x13,x11,x12 with WB write-through of x11 = 0x55
        vt[12] = '{default:0, iv:1, ordy:1, pc:32'h204, rs1:11, rs2:12, rd:13, d1:1, d2:3, op:4,
                   rw:1, ww:1, wrd:11, wres:32'h55, e_ir:1, e_ov:1, e_op:3, e_a:32'h200,
                   e_b:32'h0F, e_pc:32'h200, e_rd:8, e_rw:1, e_r2:32'h0F};
        // capture op 9 writing x0
        vt[13] = '{default:0, iv:1, ordy:1, pc:32'h208, rs1:1, rs2:2, rd:0, d1:100, d2:200, op:9,
                   rw:1, e_ir:1, e_ov:1, e_op:4, e_a:32'h55, e_b:3, e_pc:32'h204, e_rd:13,
                   e_rw:1, e_r2:3};
        // SRA offered while stalled: not accepted
        vt[14] = '{default:0, iv:1, ordy:0, pc:32'h20C, rs1:14, rs2:15, rd:16, d1:32'h80000000,
                   d2:4, op:7, rw:1, e_ir:0, e_ov:1, e_op:9, e_a:100, e_b:200, e_pc:32'h208,
                   e_rd:0, e_rw:0, e_r2:200};
        // flush while holding
        vt[15] = '{default:0, iv:1, ordy:0, fl:1, pc:32'h20C, rs1:14, rs2:15, rd:16,
                   d1:32'h80000000, d2:4, op:7, rw:1, e_ir:0, e_ov:1, e_op:9, e_a:100, e_b:200,
                   e_pc:32'h208, e_rd:0, e_rw:0, e_r2:200};
        // slot emptied; flush again discards the accepted SRA beat
        vt[16] = '{default:0, iv:1, ordy:1, fl:1, pc:32'h20C, rs1:14, rs2:15, rd:16,
                   d1:32'h80000000, d2:4, op:7, rw:1, e_ir:1, e_ov:0, e_op:4'hF, e_a:100,
                   e_b:200, e_pc:32'h208, e_rd:0, e_rw:0, e_r2:200};
        // nothing was captured
        vt[17] = '{default:0, ordy:1, e_ir:1, e_ov:0, e_op:4'hF, e_a:100, e_b:200,
                   e_pc:32'h208, e_rd:0, e_rw:0, e_r2:200};
        // offer SRA again, no flush
        vt[18] = '{default:0, iv:1, ordy:1, pc:32'h20C, rs1:14, rs2:15, rd:16, d1:32'h80000000,
                   d2:4, op:7, rw:1, e_ir:1, e_ov:0, e_op:4'hF, e_a:100, e_b:200,
                   e_pc:32'h208, e_rd:0, e_rw:0, e_r2:200};
        // SRA held, downstream stalls
        vt[19] = '{default:0, ordy:0, e_ir:0, e_ov:1, e_op:7, e_a:32'h80000000, e_b:4,
                   e_pc:32'h20C, e_rd:16, e_rw:1, e_r2:4};

        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            if (i != 0) @(negedge clk);
            apply(vt[i]);
            #1;
            check_vec(i, vt[i]);
        end

        // Reset during a stall drops the held SRA
        @(negedge clk);
        drive_idle();
        bus.out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst out_valid",     {31'd0, bus.out_valid},     32'd0);
        chk("rst alu_op",        {28'd0, bus.alu_op},        32'hF);
        chk("rst in_ready",      {31'd0, bus.in_ready},      32'd1);
        chk("rst out_reg_write", {31'd0, bus.out_reg_write}, 32'd0);
        chk("rst alu_a",         bus.alu_a,                  32'd0);
        chk("rst out_pc",        bus.out_pc,                 32'd0);

        // Four back-to-back instructions, order preserved
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive_idle();
            bus.in_valid     = 1'b1;
            bus.in_rs1_addr  = 5'd17;
            bus.in_rs1_data  = 32'(k * 10 + 1);
            bus.in_rd_addr   = 5'(20 + k);
            bus.in_alu_op    = 4'(k);
            bus.in_reg_write = 1'b1;
            #1;
            chk($sformatf("b2b%0d in_ready", k), {31'd0, bus.in_ready}, 32'd1);
            if (k > 0) begin
                chk($sformatf("b2b%0d out_valid", k), {31'd0, bus.out_valid}, 32'd1);
                chk($sformatf("b2b%0d rd", k), {27'd0, bus.out_rd_addr}, 32'(20 + k - 1));
                chk($sformatf("b2b%0d alu_a", k), bus.alu_a, 32'((k - 1) * 10 + 1));
                chk($sformatf("b2b%0d alu_op", k), {28'd0, bus.alu_op}, 32'(k - 1));
            end
        end
        @(negedge clk);
        drive_idle();
        #1;
        chk("b2b3 out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("b2b3 rd",        {27'd0, bus.out_rd_addr}, 32'd23);
        chk("b2b3 alu_a",     bus.alu_a, 32'd31);
        @(negedge clk);
        #1;
        chk("b2b drain out_valid", {31'd0, bus.out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
